uart_rx: RTL
============

# uart_rx

8N1 UART receiver with a static, configuration-time baud rate. It samples the asynchronous `rx` line in the `clk` domain and recovers one byte per frame. Each good byte is presented on `data` with a one-cycle `stb` pulse, and framing errors are flagged on `err`. It is the receive-side counterpart of the team's UART transmitter and sits between the board pin and the Wishbone-facing UART peripheral logic.

## Interface
- `pTicksPerBaud`, default 104: `clk` cycles per bit period. Must be ≥ 4, or ≥ 8 when `UART_RX_MAJORITY_EN` is defined. Let N = `pTicksPerBaud` and H = N/2, using integer division.
- `clk` in 1: single clock for all logic.
- `rst` in 1: reset; synchronous and active-high.
- `rx` in 1: asynchronous serial line. Idle is high.
- `stb` out 1: one-cycle pulse when a good byte is on `data`.
- `data` out 8: last good byte received. Holds its value until the next good frame.
- `err` out 1: one-cycle pulse on a framing error (stop bit sampled low).

## Operation
- **Line format:** idle = 1; start bit = 0; 8 data bits, LSB first, true polarity; stop bit = 1.
- **Synchronizer:** 2-flop synchronizer on `rx`, both flops reset to 1. Its output is `rx_s`. The bit sample `s` is `rx_s`, or the majority value (see Configuration).
- **Bit counter:** `baud_cnt`, width `$clog2(N)`, increments every cycle outside Idle and Break. It clears on every sample event.
- **States:** Idle, Start, Data, Stop, Break.
- **Idle:** when `rx_s` == 0, clear `baud_cnt` and go to Start. This is level-triggered, so a line held low out of reset starts a frame.
- **Start:** when `baud_cnt` == H−1, sample `s`.
  - `s` == 1: false start; go to Idle with no output.
  - `s` == 0: clear `baud_cnt`, clear `bit_idx`, go to Data.
- **Data:** when `baud_cnt` == N−1, shift `s` into the MSB of an 8-bit shifter (shift right) and increment `bit_idx`. After the 8th bit, go to Stop.
- **Stop:** when `baud_cnt` == N−1, sample `s`.
  - `s` == 1: load `data` from the shifter, pulse `stb`, go to Idle.
  - `s` == 0: pulse `err` (`data` unchanged), go to Break.
- **Break:** wait until `rx_s` == 1, then go to Idle. Stuck-low lines and break conditions therefore produce exactly one `err`.
- `stb` and `err` are never high in the same cycle.
- **Back-to-back frames:** the return to Idle at mid-stop makes them supported. A start bit directly following the stop bit is detected.

## Timing
- **Reset values:** `stb` = 0, `err` = 0, `data` = 8'h00, state = Idle, `baud_cnt` = 0, shifter = 0, synchronizer = 1.
- **Reset priority:** `rst` overrides all other assignments in the same cycle. Reset mid-frame aborts the frame silently, with no `stb` and no `err`.
- **Sample instants:** let t0 be the first cycle in Idle with `rx_s` == 0, which is 2 cycles after the pin edge.
  - Start sample at t0+H.
  - Data bit k (k = 0..7) at t0+H+(k+1)·N.
  - Stop sample at t0+H+9·N.
- **Outputs:** `stb`/`err` are registered and high in cycle t0+H+9·N+1. `data` is valid in the same cycle as `stb`.
- **Latency:** pin falling edge to `stb` is 2+H+9·N+1 cycles.
- **Throughput:** one frame per 10·N cycles at matched baud. Tolerates about ±4 % baud mismatch.

## Configuration
- `UART_RX_MAJORITY_EN` defined:
  - Keep a 3-bit history of `rx_s`; `s` = majority of the current and two previous `rx_s` values.
  - Applies to the start, data and stop samples.
  - Adds no latency to the sample instants; the window ends at the instant.
- Not defined: `s` = `rx_s` directly, and the history register is not built.

## Test plan
- **Single frame:** N = 16; send 0xA5 with correct framing → one `stb` at the cycle given by the Timing latency formula, `data` = 0xA5, `err` never high.
- **Back-to-back:** send 0x00, 0xFF, 0x3C consecutively with no idle gap → three `stb` pulses exactly 160 cycles apart, `data` sequence 0x00, 0xFF, 0x3C.
- **False start:** drive `rx` low for 4 cycles, then high → no `stb` and no `err`; the next valid frame 0x55 is received correctly.
- **Framing error then recovery:** send 0x81 with stop bit = 0 and hold the line low for 3 bit periods → exactly one `err`, no `stb`, `data` keeps its prior value; after release, frame 0x7E → `stb` with `data` = 0x7E.
- **Reset mid-frame:** assert `rst` for 1 cycle during data bit 4 of frame 0xC3 → no `stb`/`err` for that frame, outputs at reset values; the following frame 0x12 is received correctly.
- **Majority vote (`UART_RX_MAJORITY_EN`):** 1-cycle glitch to 0 on the sample instant of a 1-bit in frame 0xFF → `data` = 0xFF. Without the macro the same stimulus → `data` = 0xFE.

Source files
------------

// File: rtl/uart_rx_if.sv
// Serial-receive bundle: pin input plus the byte/strobe/error outputs of uart_rx.
// master = pin/consumer side, slave = the receiver.
interface uart_rx_if;
    logic       rx;
    logic       stb;
    logic [7:0] data;
    logic       err;

    modport master (output rx, input stb, input data, input err);
    modport slave  (input rx, output stb, output data, output err);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver, fixed baud; optional 3-sample majority vote under UART_RX_MAJORITY_EN.
// Pin edge to stb = 2+H+9N+1 cycles; no backpressure, stb/err are single-cycle pulses.
module uart_rx #(
    parameter int pTicksPerBaud = 104
) (
    input  logic      i_clk,
    input  logic      i_rst,
    uart_rx_if.slave  bus
);

    localparam int N  = pTicksPerBaud;
    localparam int H  = N / 2;
    localparam int CW = $clog2(N);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } state_t;

    state_t          r_state;
    logic            r_sync1;
    logic            r_sync2;
    logic [CW-1:0]   r_baud_cnt;
    logic [2:0]      r_bit_idx;
    logic [7:0]      r_shift;
    logic [7:0]      r_data;
    logic            r_stb;
    logic            r_err;

    logic            w_rx_s;
    logic            w_s;
    logic            w_half;
    logic            w_full;

    assign w_rx_s = r_sync2;
    assign w_half = (r_baud_cnt == CW'(H - 1));
    assign w_full = (r_baud_cnt == CW'(N - 1));

`ifdef UART_RX_MAJORITY_EN
    // Two previous rx_s values; the vote window ends on the sample instant itself.
    logic [1:0] r_hist;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_hist <= 2'b11;
        end else begin
            r_hist <= {r_hist[0], r_sync2};
        end
    end

    assign w_s = (r_sync2 & r_hist[0]) | (r_sync2 & r_hist[1]) | (r_hist[0] & r_hist[1]);
`else
    assign w_s = w_rx_s;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1    <= 1'b1;
            r_sync2    <= 1'b1;
            r_state    <= ST_IDLE;
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_data     <= '0;
            r_stb      <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_sync1 <= bus.rx;
            r_sync2 <= r_sync1;
            r_stb   <= 1'b0;
            r_err   <= 1'b0;

            if (r_state != ST_IDLE && r_state != ST_BREAK) begin
                r_baud_cnt <= r_baud_cnt + CW'(1);
            end

            case (r_state)
                ST_IDLE: begin
                    // Level-triggered: a line already low starts a frame.
                    if (!w_rx_s) begin
                        r_baud_cnt <= '0;
                        r_state    <= ST_START;
                    end
                end
                ST_START: begin
                    if (w_half) begin
                        r_baud_cnt <= '0;
                        if (w_s) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_bit_idx <= '0;
                            r_state   <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (w_full) begin
                        r_baud_cnt <= '0;
                        r_shift    <= {w_s, r_shift[7:1]};
                        r_bit_idx  <= r_bit_idx + 3'd1;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= ST_STOP;
                        end
                    end
                end
                ST_STOP: begin
                    // Leaving at mid-stop leaves room to catch a back-to-back start bit.
                    if (w_full) begin
                        r_baud_cnt <= '0;
                        if (w_s) begin
                            r_data  <= r_shift;
                            r_stb   <= 1'b1;
                            r_state <= ST_IDLE;
                        end else begin
                            r_err   <= 1'b1;
                            r_state <= ST_BREAK;
                        end
                    end
                end
                ST_BREAK: begin
                    if (w_rx_s) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.stb  = r_stb;
    assign bus.err  = r_err;
    assign bus.data = r_data;

endmodule
